// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: flow-op codes, next-PC mux operation codes and sequencer states.
package pc_sequencer_pkg;
  typedef enum logic [3:0] {
    OP_NONE, OP_BZ, OP_BNZ, OP_BC, OP_BNC, OP_JMP, OP_JSB, OP_RET, OP_RETI, OP_ENAI, OP_DISI
  } ctrl_op_t;
  localparam logic [3:0] PCOP_INC    = 4'b0000;
  localparam logic [3:0] PCOP_INTVEC = 4'b0001;
  localparam logic [3:0] PCOP_BZ     = 4'b0100;
  localparam logic [3:0] PCOP_BNZ    = 4'b0101;
  localparam logic [3:0] PCOP_BC     = 4'b0110;
  localparam logic [3:0] PCOP_BNC    = 4'b0111;
  localparam logic [3:0] PCOP_JUMP   = 4'b1000;
  localparam logic [3:0] PCOP_STACK  = 4'b1010;
  localparam logic [3:0] PCOP_INTRET = 4'b1100;
  typedef enum logic {RUN, INT_ENTRY} seq_state_t;
  function automatic logic [3:0] pcop_of(input logic [3:0] op);
    case (op)
      OP_BZ:          return PCOP_BZ;
      OP_BNZ:         return PCOP_BNZ;
      OP_BC:          return PCOP_BC;
      OP_BNC:         return PCOP_BNC;
      OP_JMP, OP_JSB: return PCOP_JUMP;
      OP_RET:         return PCOP_STACK;
      OP_RETI:        return PCOP_INTRET;
      default:        return PCOP_INC;
    endcase
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder/next-PC-mux facing signals of the PC sequencer.
interface pc_sequencer_if #(parameter int ADDR_W = 12);
  logic [3:0]        ctrl_op_i;
  logic              advance_i;
  logic              int_req_i;
  logic [ADDR_W-1:0] pc_next_i;
  logic [ADDR_W-1:0] pc_o;
  logic [3:0]        pcoper_o;
  logic [ADDR_W-1:0] stackaddr_o;
  logic [ADDR_W-1:0] intpc_o;
  logic              busy_o;
  logic              int_ack_o;
  logic              stack_err_o;
  modport master (
    output ctrl_op_i, advance_i, int_req_i, pc_next_i,
    input  pc_o, pcoper_o, stackaddr_o, intpc_o, busy_o, int_ack_o, stack_err_o
  );
  modport slave (
    input  ctrl_op_i, advance_i, int_req_i, pc_next_i,
    output pc_o, pcoper_o, stackaddr_o, intpc_o, busy_o, int_ack_o, stack_err_o
  );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: LIFO of return addresses; overflowing pushes and empty pops are dropped and flagged.
module return_stack #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic              do_push, do_pop;
  assign full_o  = sp_q == SP_W'(STACK_DEPTH);
  assign empty_o = sp_q == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign err_o   = (push_i & full_o) | (pop_i & empty_o);
  assign sp_d    = do_push ? sp_q + SP_W'(1) : do_pop ? sp_q - SP_W'(1) : sp_q;
  // empty stack reads as address 0 so an underflowing return lands on 0
  assign top_o   = empty_o ? '0 : mem_q[IDX_W'(sp_q - SP_W'(1))];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sp_q <= '0;
    else       sp_q <= sp_d;
  always_ff @(posedge clk_i)
    if (do_push) mem_q[IDX_W'(sp_q)] <= data_i;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, return stack, interrupt enable and interrupt-entry FSM driving the next-PC mux.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = 12,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input logic           clk_i,
  input logic           rst_i,
  pc_sequencer_if.slave bus
);
  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, intpc_q, intpc_d, top;
  logic              int_en_q, int_en_d, stack_err_q;
  logic              in_int, adv, push, pop, st_err, st_full, st_empty;
  assign in_int = state_q == INT_ENTRY;
  assign adv    = ~in_int & bus.advance_i;
  assign push   = adv & (bus.ctrl_op_i == OP_JSB);
  assign pop    = adv & (bus.ctrl_op_i == OP_RET);
  return_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(push), .pop_i(pop),
    .data_i(pc_q + ADDR_W'(1)), .top_o(top), .full_o(st_full), .empty_o(st_empty), .err_o(st_err)
  );
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    intpc_d  = intpc_q;
    int_en_d = int_en_q;
    if (in_int) begin
      state_d  = RUN;
      intpc_d  = pc_q;
      pc_d     = bus.pc_next_i;
      int_en_d = 1'b0;
    end else if (bus.advance_i) begin
      pc_d     = bus.pc_next_i;
      int_en_d = (bus.ctrl_op_i == OP_ENAI || bus.ctrl_op_i == OP_RETI) ? 1'b1 :
                 (bus.ctrl_op_i == OP_DISI) ? 1'b0 : int_en_q;
      // the request is qualified by the enable held before this instruction
      state_d  = (int_en_q & bus.int_req_i) ? INT_ENTRY : RUN;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q     <= RUN;
      pc_q        <= RESET_VEC;
      intpc_q     <= '0;
      int_en_q    <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      intpc_q     <= intpc_d;
      int_en_q    <= int_en_d;
      stack_err_q <= stack_err_q | st_err;
    end
  assign bus.pc_o        = pc_q;
  assign bus.pcoper_o    = in_int ? PCOP_INTVEC : pcop_of(bus.ctrl_op_i);
  assign bus.stackaddr_o = st_empty ? '0 : top;
  assign bus.intpc_o     = intpc_q;
  assign bus.busy_o      = in_int;
  assign bus.int_ack_o   = in_int;
  assign bus.stack_err_o = stack_err_q | (st_full & 1'b0);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench with a behavioural next-PC mux and an abstract sequencer model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;
  typedef struct packed {
    logic [11:0] pc, sa, ipc;
    logic        busy, ack, err;
    logic [3:0]  pcop;
  } exp_t;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        zero, carry;
  logic [11:0] off, target;
  int          checks = 0, errors = 0;
  exp_t        q[$];
  exp_t        mon_e;
  int          m_pc, m_ipc, stk[$];
  bit          m_ie, m_in, m_err;
  always #5 clk_i = ~clk_i;
  pc_sequencer_if #(.ADDR_W(12)) bus();
  pc_sequencer #(.ADDR_W(12), .STACK_DEPTH(8), .RESET_VEC(12'h000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );
  // next-PC mux placed beside the sequencer
  always_comb begin
    bus.pc_next_i = bus.pc_o + 12'd1;
    case (bus.pcoper_o)
      4'b0001: bus.pc_next_i = 12'h001;
      4'b0100: bus.pc_next_i = zero  ? bus.pc_o + off : bus.pc_o + 12'd1;
      4'b0101: bus.pc_next_i = !zero ? bus.pc_o + off : bus.pc_o + 12'd1;
      4'b0110: bus.pc_next_i = carry ? bus.pc_o + off : bus.pc_o + 12'd1;
      4'b0111: bus.pc_next_i = !carry ? bus.pc_o + off : bus.pc_o + 12'd1;
      4'b1000: bus.pc_next_i = target;
      4'b1010: bus.pc_next_i = bus.stackaddr_o;
      4'b1100: bus.pc_next_i = bus.intpc_o;
      default: ;
    endcase
  end
  function automatic logic [3:0] exp_pcop(input logic [3:0] op);
    case (op)
      OP_BZ:          return 4'b0100;
      OP_BNZ:         return 4'b0101;
      OP_BC:          return 4'b0110;
      OP_BNC:         return 4'b0111;
      OP_JMP, OP_JSB: return 4'b1000;
      OP_RET:         return 4'b1010;
      OP_RETI:        return 4'b1100;
      default:        return 4'b0000;
    endcase
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, req, $time);
    end
  endtask
  task automatic model_reset();
    m_pc = 0; m_ipc = 0; m_ie = 0; m_in = 0; m_err = 0;
    stk.delete();
  endtask
  task automatic step(input logic [3:0] op, input bit adv, input bit req, input bit z = 0,
                      input bit c = 0, input logic [11:0] o = 0, input logic [11:0] t = 0);
    exp_t e;
    bit   take;
    bus.ctrl_op_i = op; bus.advance_i = adv; bus.int_req_i = req;
    zero = z; carry = c; off = o; target = t;
    e.pc = 12'(m_pc); e.sa = stk.size() > 0 ? 12'(stk[$]) : 12'h0; e.ipc = 12'(m_ipc);
    e.busy = m_in; e.ack = m_in; e.err = m_err; e.pcop = m_in ? 4'b0001 : exp_pcop(op);
    q.push_back(e);
    if (m_in) begin
      m_ipc = m_pc; m_pc = 1; m_ie = 0; m_in = 0;
    end else if (adv) begin
      take = m_ie && req;
      case (op)
        OP_BZ:   m_pc = z  ? m_pc + int'(o) : m_pc + 1;
        OP_BNZ:  m_pc = !z ? m_pc + int'(o) : m_pc + 1;
        OP_BC:   m_pc = c  ? m_pc + int'(o) : m_pc + 1;
        OP_BNC:  m_pc = !c ? m_pc + int'(o) : m_pc + 1;
        OP_JMP:  m_pc = int'(t);
        OP_JSB: begin
          if (stk.size() < 8) stk.push_back((m_pc + 1) & 'hFFF);
          else m_err = 1;
          m_pc = int'(t);
        end
        OP_RET: begin
          if (stk.size() > 0) m_pc = stk.pop_back();
          else begin m_pc = 0; m_err = 1; end
        end
        OP_RETI: begin m_pc = m_ipc; m_ie = 1; end
        OP_ENAI: begin m_pc = m_pc + 1; m_ie = 1; end
        OP_DISI: begin m_pc = m_pc + 1; m_ie = 0; end
        default: m_pc = m_pc + 1;
      endcase
      m_pc &= 'hFFF;
      m_in = take;
    end
    @(posedge clk_i); #1;
  endtask
  always @(negedge clk_i)
    if (!rst_i && q.size() > 0) begin
      mon_e = q.pop_front();
      chk("pc_o", 32'(bus.pc_o), 32'(mon_e.pc));
      chk("stackaddr_o", 32'(bus.stackaddr_o), 32'(mon_e.sa));
      chk("intpc_o", 32'(bus.intpc_o), 32'(mon_e.ipc));
      chk("busy_o", 32'(bus.busy_o), 32'(mon_e.busy));
      chk("int_ack_o", 32'(bus.int_ack_o), 32'(mon_e.ack));
      chk("stack_err_o", 32'(bus.stack_err_o), 32'(mon_e.err));
      chk("pcoper_o", 32'(bus.pcoper_o), 32'(mon_e.pcop));
    end
  initial begin
    bus.ctrl_op_i = OP_NONE; bus.advance_i = 1'b0; bus.int_req_i = 1'b0;
    zero = 0; carry = 0; off = '0; target = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("reset pc_o", 32'(bus.pc_o), 32'h0);
    chk("reset stackaddr_o", 32'(bus.stackaddr_o), 32'h0);
    chk("reset busy_o", 32'(bus.busy_o), 32'h0);
    chk("reset stack_err_o", 32'(bus.stack_err_o), 32'h0);
    repeat (3) step(OP_NONE, 1, 0);
    step(OP_BZ, 1, 0, 1, 0, 12'hFFE);
    step(OP_JMP, 1, 0, 0, 0, 0, 12'h010);
    step(OP_JSB, 1, 0, 0, 0, 0, 12'h080);
    step(OP_NONE, 0, 0);
    step(OP_RET, 1, 0);
    step(OP_NONE, 1, 0);
    repeat (9) step(OP_JSB, 1, 0, 0, 0, 0, 12'h100);
    repeat (9) step(OP_RET, 1, 0);
    step(OP_JMP, 1, 0, 0, 0, 0, 12'h004);
    step(OP_ENAI, 1, 1);
    step(OP_NONE, 1, 1);
    step(OP_NONE, 1, 1);
    step(OP_RETI, 1, 0);
    step(OP_NONE, 1, 0);
    step(OP_NONE, 1, 1);
    chk("int_ack before reset", 32'(bus.int_ack_o), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("async reset pc_o", 32'(bus.pc_o), 32'h0);
    chk("async reset int_ack_o", 32'(bus.int_ack_o), 32'h0);
    chk("async reset busy_o", 32'(bus.busy_o), 32'h0);
    model_reset();
    q.delete();
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (600)
      step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           1'($urandom), 1'($urandom), 12'($urandom), 12'($urandom));
    @(negedge clk_i); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
